// File: rtl/fetch_decode_pipe.sv
// fetch_decode_pipe: in-order buffer of {code, code_index} entries between
// the fetch and decode stages. It holds up to 'depth' entries, each one
// delivered one cycle after it was accepted. A flush throws away everything
// that is buffered, together with any entry offered on the same edge.
//
// Handshake: an entry moves on a rising edge only when its valid and ready
// are both 1 on that edge, and a producer that has raised valid keeps it
// raised, with the data held stable, until the entry is accepted. in_ready
// and out_valid come only from registered occupancy. in_ready therefore
// never depends on out_ready or in_valid in the same cycle, and out_valid
// never depends on in_valid.
module fetch_decode_pipe #(
  parameter int code_size  = 12,
  parameter int index_size = 32,
  parameter int depth      = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         flush,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [code_size-1:0]         code,
  input  logic [index_size-1:0]        code_index,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [code_size-1:0]         code_out,
  output logic [index_size-1:0]        code_index_out,
  output logic [$clog2(depth+1)-1:0]   count
);

  // Occupancy counter width and pointer width. The pointer is at least one
  // bit wide so that depth=1 still has a legal vector.
  localparam int CW = $clog2(depth + 1);
  localparam int PW = (depth > 1) ? $clog2(depth) : 1;
  // Storage is rounded up to a power of two so that every pointer value
  // addresses a real entry. Only entries 0..depth-1 are ever used.
  localparam int MEM_WORDS = 1 << PW;
  localparam logic [PW-1:0] LAST_PTR = PW'(depth - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(depth);

  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;

  logic [code_size-1:0]  code_mem  [MEM_WORDS];
  logic [index_size-1:0] index_mem [MEM_WORDS];

  logic push;
  logic pop;

  // Advance a pointer and wrap it after depth-1. This also covers depths
  // that are not a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    next_ptr = (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Status flags and qualified transfers. The flags come only from state.
  always_comb begin
    in_ready  = (count_q < FULL_CNT);
    out_valid = (count_q != '0);
    push      = in_valid & in_ready & ~flush;
    pop       = out_valid & out_ready & ~flush;
  end

  // Next-state for occupancy and pointers. A flush empties the buffer and
  // overrides any push or pop on the same edge.
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register. Reset takes priority over flush, push and pop.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Entry storage has no reset. The data outputs are masked while the
  // buffer is empty, so stale contents are never visible.
  always_ff @(posedge clk) begin
    if (push && !reset) begin
      code_mem[wr_ptr_q]  <= code;
      index_mem[wr_ptr_q] <= code_index;
    end
  end

  // The head entry is driven only while it is valid, and is zero otherwise.
  always_comb begin
    code_out       = '0;
    code_index_out = '0;
    if (out_valid) begin
      code_out       = code_mem[rd_ptr_q];
      code_index_out = index_mem[rd_ptr_q];
    end
  end

  assign count = count_q;

endmodule
